fifo_serial_tx: RTL and testbench
=================================

// Module: fifo_serial_tx
// PURPOSE
//  Read-side consumer for the async FIFO: pops 4-bit words from the FIFO read port and sends each as a serial frame on one pin.
//  Sits in the rclk domain, driving the FIFO's rinc and taking rdata/empty, so FIFO contents leave the chip without per-word pin toggling.
//  Frame: start(0), DATA_WIDTH data bits LSB-first, optional even parity, 1 stop(1); line idles high.
// PARAMETERS
//  DATA_WIDTH    4  FIFO word width / data bits per frame
//  CLKS_PER_BIT  4  clk cycles per serial bit; legal range 1..255
//  PARITY_EN     1  1 = append even-parity bit after data; 0 = omit
// PORTS
//  clk          in   1           single clock (FIFO read clock); all logic on posedge
//  rst_n        in   1           asynchronous, active-low reset
//  en           in   1           1 = allowed to start new frames
//  empty        in   1           FIFO empty flag (registered in clk domain)
//  rdata        in   DATA_WIDTH  FIFO head word; valid combinationally whenever empty=0 (show-ahead)
//  rinc         out  1           1-cycle pop strobe to FIFO
//  tx           out  1           serial line
//  busy         out  1           1 while a frame is in flight (LOAD..STOP)
//  frame_done   out  1           1-cycle pulse in last cycle of stop bit
//  frame_cnt    out  8           frames completed since reset, wraps 255->0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx=1, rinc=0, busy=0, frame_done=0, frame_cnt=0, shift reg=0, bit timer=0.
//  States: IDLE, LOAD, START, DATA, PARITY, STOP.
//  IDLE: tx=1. If en=1 && empty=0 -> rinc=1 combinationally this cycle, shreg<=rdata, parity<=^rdata, go LOAD.
//  LOAD: one cycle, tx=1, rinc=0 (lets FIFO update empty); go START, bit timer cleared.
//  START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
//  DATA: tx=shreg[0]; each CLKS_PER_BIT cycles shift right, index++; after DATA_WIDTH bits -> PARITY if PARITY_EN else STOP.
//  PARITY: tx=even parity (XOR of data bits) for CLKS_PER_BIT cycles -> STOP.
//  STOP: tx=1 for CLKS_PER_BIT cycles; last cycle frame_done=1, frame_cnt++ -> IDLE.
//  Frame length: CLKS_PER_BIT*(2+DATA_WIDTH+PARITY_EN) cycles from START entry; plus IDLE+LOAD = 2-cycle minimum inter-frame gap at tx=1.
//  rinc: never high outside IDLE, never in consecutive cycles, never while empty=1.
//  tx is registered (no glitches); rinc and word capture happen in the same cycle.
//  en=0 mid-frame: current frame completes unaltered; no new pop afterwards.
//  empty rising mid-frame: ignored; only sampled in IDLE.
//  Reset mid-frame: frame abandoned, tx=1 immediately; popped word lost (no re-push).
//  Timer width = $clog2(CLKS_PER_BIT+1); CLKS_PER_BIT=1 gives one cycle per bit.
//  busy = (state != IDLE).
// STRUCTURE
//  fifo_pkg: state encoding localparams (IDLE..STOP), DATA_WIDTH default, FRAME_BITS function.
//  Sub-module bit_tick_gen: counter 0..CLKS_PER_BIT-1, sync clear on state entry, tick output at terminal count.
//  Top holds FSM, shift register, parity bit, bit index, frame_cnt.
// TESTING (CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
//  Reset hold: rst_n=0, empty=0, en=1 -> tx=1, rinc=0, busy=0, frame_cnt=0 throughout.
//  Single word: rdata=4'hA, empty=0 one word, en=1 -> rinc pulse 1 cycle, then tx = 0000 0000 1111 0000 1111 0000 1111 (start, 0,1,0,1, parity 0, stop), 28 cycles; frame_done once, frame_cnt=1.
//  Back-to-back: FIFO holds 4'h3 then 4'hC -> two rinc pulses 30 cycles apart; parity bits 0 and 0; 2 idle-high cycles between frames; frame_cnt=2.
//  Parity odd data: rdata=4'h7, PARITY_EN=1 -> parity bit 1; PARITY_EN=0 build -> 24-cycle frame, no parity slot.
//  en drop mid-frame: deassert en during DATA with FIFO non-empty -> frame completes, no further rinc until en=1.
//  Reset mid-frame: assert rst_n=0 during DATA -> tx=1 same cycle, busy=0; after release with empty=0, next frame starts cleanly with fresh pop.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO read-side serial transmitter:
// FSM state encoding, default word width and a frame-size helper.
package fifo_serial_tx_pkg;

  localparam int DATA_WIDTH_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  // Serial bit slots in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_width, input int parity_en);
    return 2 + data_width + parity_en;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial-line status bundle. The slave modport is
// the transmitter; the master modport is whatever owns the FIFO and
// watches the line.
interface fifo_serial_tx_if import fifo_serial_tx_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;
  logic [7:0]            frame_cnt;

  modport master (
    output en, empty, rdata,
    input  rinc, tx, busy, frame_done, frame_cnt
  );

  modport slave (
    input  en, empty, rdata,
    output rinc, tx, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/fifo_serial_tx_bit_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal
// count. clear_i restarts the period; the FSM pulses it on every state
// change so each state begins on a fresh bit boundary.
module fifo_serial_tx_bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);
  localparam int              TW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]   LAST_CNT = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST_CNT);

  // Next count: wrap at terminal count or on an explicit clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and sends each as a serial frame:
// start(0), data LSB-first, optional even parity, stop(1); idle high.
// rst_n is expected to come from a reset synchroniser (async assert,
// sync release) in the rclk domain.
module fifo_serial_tx import fifo_serial_tx_pkg::*; #(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_serial_tx_if.slave bus
);
  localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  pop;
  logic                  done;
  logic                  tick;

  fifo_serial_tx_bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_d != state_q),
    .tick_o  (tick)
  );

  // Frame sequencing, word capture and line value for the next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned; otherwise synthesis infers latches.
    state_d     = state_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && !bus.empty) begin
          pop     = 1'b1;
          shreg_d = bus.rdata;
          par_d   = ^bus.rdata;
          state_d = ST_LOAD;
        end
      end
      // One quiet cycle so the FIFO can update empty after the pop.
      ST_LOAD: state_d = ST_START;
      ST_START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          done        = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line value follows the state being entered, so tx_q lines up
    // with state_q and carries no decode glitches.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops the frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The pop strobe is combinational from IDLE; masking it with rst_n
  // keeps the FIFO untouched while the block is held in reset.
  assign bus.rinc       = pop & rst_n;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = done;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-backed FIFO model feeds the DUT, each
// pushed word queues its expected frame, and a line monitor captures every
// frame and compares it against a waveform rebuilt from the word.
module tb_fifo_serial_tx;
  import fifo_serial_tx_pkg::*;

  localparam int DW      = 4;
  localparam int CPB     = 4;
  localparam int FLEN    = CPB * frame_bits(DW, 1);
  localparam int FLEN_NP = CPB * frame_bits(DW, 0);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_serial_tx_if #(.DATA_WIDTH(DW)) bus ();
  fifo_serial_tx_if #(.DATA_WIDTH(DW)) bus_np ();

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_np)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expected);
    n_checks++;
    if (act !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expected);
    end
  endtask

  // Expected tx per cycle, starting at the pop cycle: 2 idle-high cycles
  // (IDLE, LOAD) then CPB cycles per frame slot.
  function automatic logic [63:0] make_wave(input logic [DW-1:0] w, input bit par, input int flen);
    logic [63:0] v;
    int b;
    v = '0;
    for (int c = 0; c < flen + 2; c++) begin
      if (c < 2) v[c] = 1'b1;
      else begin
        b = (c - 2) / CPB;
        if (b == 0)                 v[c] = 1'b0;
        else if (b <= DW)           v[c] = w[b-1];
        else if (par && b == DW+1)  v[c] = ^w;
        else                        v[c] = 1'b1;
      end
    end
    return v;
  endfunction

  // FIFO model and scoreboard
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            frames_expected = 0;
  bit            do_pop;

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    frames_expected++;
  endtask

  initial begin
    bus.empty = 1'b1;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      do_pop = bus.rinc;
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.empty = (fifo_q.size() == 0);
      if (fifo_q.size() > 0) bus.rdata = fifo_q[0];
    end
  end

  // Line monitor
  bit            mon_active = 1'b0;
  int            mon_cyc    = 0;
  int            cyc_cnt    = 0;
  int            rinc_cnt   = 0;
  int            rinc_viol  = 0;
  int            frames_checked = 0;
  int            rinc_times[$];
  logic [63:0]   wave, done_mask;
  bit            busy_ok;
  logic [DW-1:0] exp_word;

  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (bus.rinc && (mon_active || bus.empty)) rinc_viol++;
      if (bus.rinc) begin
        rinc_cnt++;
        rinc_times.push_back(cyc_cnt);
      end
      if (!mon_active && bus.rinc) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        wave       = '0;
        done_mask  = '0;
        busy_ok    = 1'b1;
        exp_word   = '0;
        if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else                   exp_word = exp_q.pop_front();
      end
      if (mon_active) begin
        wave[mon_cyc]      = bus.tx;
        done_mask[mon_cyc] = bus.frame_done;
        if (mon_cyc == 0 && bus.busy)  busy_ok = 1'b0;
        if (mon_cyc >= 1 && !bus.busy) busy_ok = 1'b0;
        if (mon_cyc == FLEN + 1) begin
          check("frame_wave", wave, make_wave(exp_word, 1'b1, FLEN));
          check("frame_done", done_mask, 64'd1 << (FLEN + 1));
          check("frame_busy", 64'(busy_ok), 64'd1);
          frames_checked++;
          mon_active = 1'b0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    bit timed_out;
    n = 0;
    timed_out = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n >= budget) timed_out = 1'b1;
    end while (!timed_out && !(n > 2 && fifo_q.size() == 0 && !mon_active && !bus.busy));
    check("idle_timeout", 64'(timed_out), 64'd0);
  endtask

  task automatic wait_frame_cyc(input int target, input int budget);
    int n;
    bit timed_out;
    n = 0;
    timed_out = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n >= budget) timed_out = 1'b1;
    end while (!timed_out && !(mon_active && mon_cyc >= target));
    check("frame_wait_timeout", 64'(timed_out), 64'd0);
  endtask

  int          bad_tx, bad_rinc, bad_busy, bad_cnt, base, saved;
  bit          np_rinc;
  logic [63:0] wave_np, done_np;

  initial begin
    bus.en       = 1'b1;
    bus_np.en    = 1'b0;
    bus_np.empty = 1'b1;
    bus_np.rdata = '0;
    #1 rst_n = 1'b0;

    // Reset hold with a word waiting and en=1: nothing may move.
    push_word(4'hA);
    bad_tx = 0; bad_rinc = 0; bad_busy = 0; bad_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx !== 1'b1)        bad_tx++;
      if (bus.rinc !== 1'b0)      bad_rinc++;
      if (bus.busy !== 1'b0)      bad_busy++;
      if (bus.frame_cnt !== 8'd0) bad_cnt++;
    end
    check("rst_tx", 64'(bad_tx), 64'd0);
    check("rst_rinc", 64'(bad_rinc), 64'd0);
    check("rst_busy", 64'(bad_busy), 64'd0);
    check("rst_cnt", 64'(bad_cnt), 64'd0);
    check("rst_fifo_nonempty", 64'(bus.empty), 64'd0);

    // Single word 4'hA.
    @(posedge clk); #2 rst_n = 1'b1;
    wait_idle(200);
    check("single_cnt", 64'(bus.frame_cnt), 64'd1);
    check("single_rinc", 64'(rinc_cnt), 64'd1);

    // Back-to-back 4'h3, 4'hC: pops 30 cycles apart.
    base = rinc_times.size();
    push_word(4'h3);
    push_word(4'hC);
    wait_idle(300);
    check("b2b_pops", 64'(rinc_times.size() - base), 64'd2);
    if (rinc_times.size() >= base + 2)
      check("b2b_gap", 64'(rinc_times[base+1] - rinc_times[base]), 64'd30);
    check("b2b_cnt", 64'(bus.frame_cnt), 64'd3);

    // Odd-weight data: parity slot high.
    push_word(4'h7);
    wait_idle(200);
    check("odd_cnt", 64'(bus.frame_cnt), 64'd4);

    // en dropped during DATA with a word still queued.
    push_word(4'h5);
    push_word(4'h6);
    wait_frame_cyc(8, 100);
    bus.en = 1'b0;
    saved = rinc_cnt;
    repeat (60) @(negedge clk);
    check("endrop_rinc", 64'(rinc_cnt), 64'(saved));
    check("endrop_fifo", 64'(fifo_q.size()), 64'd1);
    check("endrop_cnt", 64'(bus.frame_cnt), 64'd5);
    bus.en = 1'b1;
    wait_idle(200);
    check("enrise_cnt", 64'(bus.frame_cnt), 64'd6);

    // Reset during DATA: word 9 is lost, 4'hB goes out cleanly after.
    push_word(4'h9);
    push_word(4'hB);
    wait_frame_cyc(10, 100);
    @(posedge clk); #2 rst_n = 1'b0;
    frames_expected--;
    #1;
    check("midrst_tx", 64'(bus.tx), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_cnt", 64'(bus.frame_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle(200);
    check("midrst_after_cnt", 64'(bus.frame_cnt), 64'd1);

    // 255 more random frames: counter wraps 255 -> 0.
    for (int i = 0; i < 255; i++) push_word(DW'($urandom_range(0, 15)));
    wait_idle(9000);
    check("wrap_cnt", 64'(bus.frame_cnt), 64'd0);
    check("rinc_rules", 64'(rinc_viol), 64'd0);
    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    check("frames_checked", 64'(frames_checked), 64'(frames_expected));

    // Parity disabled build: 24-cycle frame for 4'h7, no parity slot.
    @(negedge clk);
    bus_np.rdata = 4'h7;
    bus_np.empty = 1'b0;
    bus_np.en    = 1'b1;
    #1;
    np_rinc    = bus_np.rinc;
    wave_np    = '0;
    done_np    = '0;
    wave_np[0] = bus_np.tx;
    done_np[0] = bus_np.frame_done;
    @(posedge clk); #1;
    bus_np.empty = 1'b1;
    bus_np.en    = 1'b0;
    for (int c = 1; c <= FLEN_NP + 1; c++) begin
      @(negedge clk);
      wave_np[c] = bus_np.tx;
      done_np[c] = bus_np.frame_done;
    end
    check("np_rinc", 64'(np_rinc), 64'd1);
    check("np_wave", wave_np, make_wave(4'h7, 1'b0, FLEN_NP));
    check("np_done", done_np, 64'd1 << (FLEN_NP + 1));
    @(negedge clk);
    check("np_cnt", 64'(bus_np.frame_cnt), 64'd1);
    check("np_busy", 64'(bus_np.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
